// File: rtl/ip_codma_machine_states_pkg.sv
// Shared state encodings and types for the CODMA channel machines and CRC arbiter.
package ip_codma_machine_states_pkg;

  typedef enum logic [1:0] {
    CRC_ARB_IDLE,
    CRC_ARB_START,
    CRC_ARB_WAIT,
    CRC_ARB_RESP
  } crc_arb_state_t;

  typedef logic [7:0][31:0] crc_block_t;

  localparam int CRC_ARB_DEFAULT_TIMEOUT = 64;

  // A single requester still needs a 1-bit id field.
  function automatic int crc_arb_id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ip_codma_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or above rr_ptr, wrapping.
module ip_codma_rr_arbiter
  import ip_codma_machine_states_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = crc_arb_id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any_valid
);

  // One spare bit so ptr+offset can exceed NUM_REQ before the wrap.
  logic [ID_W:0] idx;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!any_valid && valid[idx[ID_W-1:0]]) begin
        any_valid              = 1'b1;
        grant[idx[ID_W-1:0]]   = 1'b1;
        grant_id               = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ip_codma_crc_arbiter.sv
// Shares one CRC engine between NUM_REQ DMA requesters, round-robin, one block in flight.
// Optional watchdog on the engine is enabled with CODMA_CRC_TIMEOUT_EN.
module ip_codma_crc_arbiter
  import ip_codma_machine_states_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int CRC_W          = 16,
  parameter int TIMEOUT_CYCLES = CRC_ARB_DEFAULT_TIMEOUT
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  input  crc_block_t [NUM_REQ-1:0]          req_data_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  output logic                              crc_start_o,
  output crc_block_t                        crc_data_o,
  input  logic                              crc_done_i,
  input  logic [CRC_W-1:0]                  crc_result_i,
  output logic                              resp_valid_o,
  input  logic                              resp_ready_i,
  output logic [crc_arb_id_w(NUM_REQ)-1:0]  resp_id_o,
  output logic [CRC_W-1:0]                  resp_crc_o,
  output logic                              resp_err_o
);

  localparam int ID_W = crc_arb_id_w(NUM_REQ);

  crc_arb_state_t     state, state_nx;
  logic [ID_W-1:0]    rr_ptr, ptr_nx, grant_id;
  logic [NUM_REQ-1:0] grant;
  logic               any_valid, accept, done_hit, timeout_hit;

  ip_codma_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .valid     (req_valid_i),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_id  (grant_id),
    .any_valid (any_valid)
  );

  // Ready is only offered while idle; masked during reset so all outputs read 0.
  assign req_ready_o  = (state == CRC_ARB_IDLE && !reset_i) ? grant : '0;
  assign accept       = (state == CRC_ARB_IDLE) && any_valid;
  assign crc_start_o  = (state == CRC_ARB_START);
  assign resp_valid_o = (state == CRC_ARB_RESP);
  assign done_hit     = (state == CRC_ARB_WAIT) && crc_done_i;
  assign ptr_nx       = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= CRC_ARB_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      CRC_ARB_IDLE:  if (any_valid) state_nx = CRC_ARB_START;
      CRC_ARB_START: state_nx = CRC_ARB_WAIT;
      CRC_ARB_WAIT:  if (crc_done_i || timeout_hit) state_nx = CRC_ARB_RESP;
      CRC_ARB_RESP:  if (resp_ready_i) state_nx = CRC_ARB_IDLE;
      default:       state_nx = CRC_ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_ptr     <= '0;
      crc_data_o <= '0;
      resp_id_o  <= '0;
      resp_crc_o <= '0;
    end else begin
      if (accept) begin
        crc_data_o <= req_data_i[grant_id];
        resp_id_o  <= grant_id;
        rr_ptr     <= ptr_nx;
      end
      if (done_hit)         resp_crc_o <= crc_result_i;
      else if (timeout_hit) resp_crc_o <= '0;
    end
  end

`ifdef CODMA_CRC_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                     wd_cnt <= '0;
    else if (state == CRC_ARB_START) wd_cnt <= '0;
    else if (state == CRC_ARB_WAIT)  wd_cnt <= wd_cnt + 1'b1;
  end

  // A done in the expiry cycle takes priority over the timeout.
  assign timeout_hit = (state == CRC_ARB_WAIT) && !crc_done_i &&
                       (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)          resp_err_o <= 1'b0;
    else if (done_hit)    resp_err_o <= 1'b0;
    else if (timeout_hit) resp_err_o <= 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
  assign resp_err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_ip_codma_crc_arbiter.sv
// Randomized + directed bench for ip_codma_crc_arbiter against a transaction-level model.
module tb_ip_codma_crc_arbiter;
  import ip_codma_machine_states_pkg::*;

  localparam int N  = 4;
  localparam int CW = 16;
  localparam int TO = 64;

  logic               clk_i = 1'b0;
  logic               reset_i;
  logic [N-1:0]       req_valid_i, req_ready_o;
  crc_block_t [N-1:0] req_data_i;
  logic               crc_start_o;
  crc_block_t         crc_data_o;
  logic               crc_done_i;
  logic [CW-1:0]      crc_result_i;
  logic               resp_valid_o, resp_ready_i;
  logic [1:0]         resp_id_o;
  logic [CW-1:0]      resp_crc_o;
  logic               resp_err_o;

  ip_codma_crc_arbiter #(.NUM_REQ(N), .CRC_W(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .crc_start_o(crc_start_o), .crc_data_o(crc_data_o),
    .crc_done_i(crc_done_i), .crc_result_i(crc_result_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_id_o(resp_id_o), .resp_crc_o(resp_crc_o), .resp_err_o(resp_err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0, bad = 0;

  // Model: at most one transaction in flight, described by its accept cycle and response cycle.
  int         cyc = 0;
  bit         m_busy;
  int         m_acc, m_resp, m_ptr, m_id;
  crc_block_t m_data;
  logic [CW-1:0] m_crc;
  bit         m_err;

  // Observations of the DUT, for the literal expectations.
  int            start_seen, first_resp;
  int            n_start, n_ready_nz, n_rv_low;
  int            dut_id[$];
  logic [CW-1:0] dut_crc[$];
  bit            dut_err[$];

  // Stimulus knobs.
  int            vmode, rmode, emode, lat;
  logic [N-1:0]  vfix;
  logic [CW-1:0] res_fix;

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int win(logic [N-1:0] v, int p);
    for (int i = 0; i < N; i++) begin
      automatic int k = (p + i) % N;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_id = 0; m_data = '0; m_crc = '0; m_err = 0;
    m_acc = 0; m_resp = -1;
  endtask

  task automatic model_step();
    int w;
    bit rv;
    if (!reset_i) begin
      rv = m_busy && m_resp >= 0 && cyc >= m_resp;
      if (!m_busy) begin
        w = win(req_valid_i, m_ptr);
        if (w >= 0) begin
          m_busy = 1; m_acc = cyc; m_resp = -1; m_id = w;
          m_data = req_data_i[w]; m_ptr = (w + 1) % N;
        end
      end else if (rv) begin
        if (resp_ready_i) m_busy = 0;
      end else if (m_resp < 0 && cyc >= m_acc + 2) begin
        if (crc_done_i) begin
          m_resp = cyc + 1; m_crc = crc_result_i; m_err = 0;
        end
`ifdef CODMA_CRC_TIMEOUT_EN
        else if (cyc - m_acc - 1 == TO) begin
          m_resp = cyc + 1; m_crc = '0; m_err = 1;
        end
`endif
      end
    end
    cyc++;
  endtask

  task automatic check();
    logic [N-1:0] exp_ready;
    int w;
    exp_ready = '0;
    if (!reset_i && !m_busy) begin
      w = win(req_valid_i, m_ptr);
      if (w >= 0) exp_ready[w] = 1'b1;
    end
    chk("req_ready",  256'(req_ready_o),  256'(exp_ready));
    chk("crc_start",  256'(crc_start_o),  256'(!reset_i && m_busy && cyc == m_acc + 1));
    chk("crc_data",   256'(crc_data_o),   256'(m_data));
    chk("resp_valid", 256'(resp_valid_o), 256'(!reset_i && m_busy && m_resp >= 0 && cyc >= m_resp));
    chk("resp_id",    256'(resp_id_o),    256'(m_id));
    chk("resp_crc",   256'(resp_crc_o),   256'(m_crc));
    chk("resp_err",   256'(resp_err_o),   256'(m_err));
    if (crc_start_o) start_seen = cyc;
    if (resp_valid_o && first_resp < 0) first_resp = cyc;
    if (resp_valid_o && resp_ready_i) begin
      dut_id.push_back(int'(resp_id_o));
      dut_crc.push_back(resp_crc_o);
      dut_err.push_back(resp_err_o);
    end
    n_start    += int'(crc_start_o);
    n_ready_nz += int'(|req_ready_o);
    n_rv_low   += int'(!resp_valid_o);
  endtask

  task automatic drive();
    req_valid_i = (vmode == 0) ? N'($urandom) : vfix;
    if (vmode == 0)
      for (int r = 0; r < N; r++)
        for (int w = 0; w < 8; w++) req_data_i[r][w] = $urandom;
    case (rmode)
      0:       resp_ready_i = ($urandom_range(0, 2) != 0);
      1:       resp_ready_i = 1'b1;
      default: resp_ready_i = 1'b0;
    endcase
    case (emode)
      0:       crc_done_i = ($urandom_range(0, 3) == 0);
      1:       crc_done_i = (cyc == start_seen + lat);
      3:       crc_done_i = 1'b1;
      default: crc_done_i = 1'b0;
    endcase
    crc_result_i = (emode == 0) ? CW'($urandom) : res_fix;
  endtask

  task automatic tick();
    #1 check();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_ready"}, 256'(req_ready_o),  256'(0));
    chk({tag, "_start"}, 256'(crc_start_o),  256'(0));
    chk({tag, "_data"},  256'(crc_data_o),   256'(0));
    chk({tag, "_rv"},    256'(resp_valid_o), 256'(0));
    chk({tag, "_id"},    256'(resp_id_o),    256'(0));
    chk({tag, "_crc"},   256'(resp_crc_o),   256'(0));
    chk({tag, "_err"},   256'(resp_err_o),   256'(0));
  endtask

  // Asynchronous assert at the current point, one full cycle held, then released.
  task automatic do_reset(string tag);
    reset_i = 1'b1;
    model_reset();
    start_seen = -1000; first_resp = -1;
    req_valid_i = '0; crc_done_i = 1'b0; resp_ready_i = 1'b0;
    vfix = '0;
    #1 check_zero(tag);
    tick();
    reset_i = 1'b0;
  endtask

  task automatic clear_obs();
    dut_id.delete(); dut_crc.delete(); dut_err.delete();
    start_seen = -1000; first_resp = -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    reset_i = 1'b1; req_valid_i = '0; req_data_i = '0; crc_done_i = 1'b0;
    crc_result_i = '0; resp_ready_i = 1'b0;
    vmode = 1; rmode = 1; emode = 2; lat = 2; vfix = '0; res_fix = '0;
    model_reset();
    @(negedge clk_i);

    // Single request, engine latency 5.
    do_reset("rst0");
    for (int w = 0; w < 8; w++) req_data_i[0][w] = 32'h0000_69F2;
    vfix = 4'b0001; rmode = 1; emode = 1; lat = 5; res_fix = 16'h1D0F;
    clear_obs();
    t0 = cyc;
    drive(); tick();
    vfix = '0;
    for (int k = 0; k < 40 && dut_id.size() == 0; k++) begin drive(); tick(); end
    chk("single_n",     256'(dut_id.size()),    256'(1));
    chk("single_start", 256'(start_seen - t0),  256'(1));
    chk("single_rv",    256'(first_resp - t0),  256'(7));
    chk("single_id",    256'(dut_id[0]),        256'(0));
    chk("single_crc",   256'(dut_crc[0]),       256'(16'h1D0F));
    chk("single_err",   256'(dut_err[0]),       256'(0));

    // Contention from reset: all four valid.
    do_reset("rst1");
    for (int r = 0; r < N; r++)
      for (int w = 0; w < 8; w++) req_data_i[r][w] = $urandom;
    vfix = 4'b1111; rmode = 1; emode = 1; lat = 2;
    clear_obs();
    for (int k = 0; k < 100 && dut_id.size() < 4; k++) begin drive(); tick(); end
    chk("cont_n", 256'(dut_id.size()), 256'(4));
    for (int i = 0; i < 4; i++) chk("cont_id", 256'(dut_id[i]), 256'(i));

    // Fairness: req1 and req3 only.
    vfix = 4'b1010; emode = 0;
    clear_obs();
    for (int k = 0; k < 400 && dut_id.size() < 8; k++) begin drive(); tick(); end
    chk("fair_n", 256'(dut_id.size()), 256'(8));
    for (int i = 0; i < 8; i++) chk("fair_id", 256'(dut_id[i]), 256'((i % 2) ? 3 : 1));

    // Backpressure: response held for 10 cycles.
    vfix = 4'b1111; rmode = 2; emode = 1; lat = 3;
    clear_obs();
    for (int k = 0; k < 50 && first_resp < 0; k++) begin drive(); tick(); end
    chk("bp_seen", 256'(first_resp >= 0), 256'(1));
    n_start = 0; n_ready_nz = 0; n_rv_low = 0;
    repeat (10) begin drive(); tick(); end
    chk("bp_start",  256'(n_start),    256'(0));
    chk("bp_ready",  256'(n_ready_nz), 256'(0));
    chk("bp_rvlow",  256'(n_rv_low),   256'(0));
    vfix = '0; rmode = 1;
    for (int k = 0; k < 20 && m_busy; k++) begin drive(); tick(); end

    // Reset during WAIT; a late done must be ignored.
    vfix = 4'b0010; emode = 2;
    clear_obs();
    drive(); tick();
    vfix = '0;
    for (int k = 0; k < 20 && !(start_seen >= 0 && cyc >= start_seen + 3); k++) begin drive(); tick(); end
    do_reset("rstmid");
    emode = 3; res_fix = 16'h5A5A;
    drive(); tick();
    emode = 2;
    repeat (2) begin drive(); tick(); end
    vfix = 4'b0101;
    drive();
    #1 chk("rstmid_grant", 256'(req_ready_o), 256'(4'b0001));
    tick();
    vfix = '0; emode = 1; lat = 2;
    for (int k = 0; k < 20 && m_busy; k++) begin drive(); tick(); end

    // Engine that never answers.
    vfix = 4'b0001; emode = 2; rmode = 1;
    clear_obs();
    drive(); tick();
    vfix = '0;
    repeat (80) begin drive(); tick(); end
`ifdef CODMA_CRC_TIMEOUT_EN
    chk("to_n",   256'(dut_id.size()),          256'(1));
    chk("to_lat", 256'(first_resp - start_seen), 256'(65));
    chk("to_err", 256'(dut_err[0]),             256'(1));
    chk("to_crc", 256'(dut_crc[0]),             256'(0));
`else
    chk("nto_rv", 256'(first_resp), 256'(-1));
    emode = 3; res_fix = 16'hBEEF;
    drive(); tick();
    emode = 2;
    for (int k = 0; k < 10 && dut_id.size() == 0; k++) begin drive(); tick(); end
    chk("nto_n",   256'(dut_id.size()), 256'(1));
    chk("nto_crc", 256'(dut_crc[0]),    256'(16'hBEEF));
    chk("nto_err", 256'(dut_err[0]),    256'(0));
`endif

    // Random traffic.
    vmode = 0; rmode = 0; emode = 0;
    repeat (3000) begin drive(); tick(); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
